// File: rtl/cnt_arbiter.sv
// Round-robin owner of a shared event counter: a grant buys a burst of len
// increments, ended early if the owner drops req.
module cnt_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 16,
  parameter int LW   = 8,
  parameter int IW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*LW-1:0] len,
  input  logic              clr,
  output logic [NREQ-1:0]   gnt,
  output logic [IW-1:0]     owner,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CW-1:0]     count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_state_nx;
  logic [NREQ-1:0] r_gnt,   w_gnt_nx;
  logic [IW-1:0]   r_owner, w_owner_nx;
  logic [IW-1:0]   r_rr,    w_rr_nx;
  logic [LW-1:0]   r_rem,   w_rem_nx;
  logic [CW-1:0]   r_cnt,   w_cnt_nx;
  logic            r_done,  w_done_nx;
  logic            r_abort, w_abort_nx;

  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic [IW:0]     w_idx;
  logic [LW-1:0]   w_len;

  // First pending requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_rr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NREQ)) w_idx = w_idx - (IW+1)'(NREQ);
      if (!w_found && req[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[IW-1:0];
      end
    end
  end

  assign w_len = len[int'(w_pick)*LW +: LW];

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_owner_nx = r_owner;
    w_rr_nx    = r_rr;
    w_rem_nx   = r_rem;
    w_cnt_nx   = r_cnt;
    w_done_nx  = 1'b0;
    w_abort_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr) begin
          w_cnt_nx = '0;
        end else if (w_found) begin
          w_owner_nx = w_pick;
          w_rem_nx   = w_len;
          if (w_len == '0) begin
            w_done_nx  = 1'b1;
            w_state_nx = S_DONE;
          end else begin
            w_gnt_nx         = '0;
            w_gnt_nx[w_pick] = 1'b1;
            w_state_nx       = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!req[r_owner]) begin
          w_gnt_nx   = '0;
          w_done_nx  = 1'b1;
          w_abort_nx = 1'b1;
          w_state_nx = S_DONE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
          w_rem_nx = r_rem - 1'b1;
          if (r_rem == LW'(1)) begin
            w_gnt_nx   = '0;
            w_done_nx  = 1'b1;
            w_state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_rr_nx    = (r_owner == IW'(NREQ-1)) ? '0 : r_owner + 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_rr    <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_owner <= w_owner_nx;
      r_rr    <= w_rr_nx;
      r_rem   <= w_rem_nx;
      r_cnt   <= w_cnt_nx;
      r_done  <= w_done_nx;
      r_abort <= w_abort_nx;
    end
  end

  assign gnt     = r_gnt;
  assign owner   = r_owner;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign aborted = r_abort;
  assign count   = r_cnt;

endmodule

// File: tb/tb_cnt_arbiter.sv
// Directed bench for cnt_arbiter: expected burst results are queued with the
// stimulus and checked by a monitor on every done pulse.
module tb_cnt_arbiter;
  localparam int NREQ = 4, CW = 16, LW = 8, IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*LW-1:0] len;
  logic              clr;
  logic [NREQ-1:0]   gnt, gnt_w;
  logic [IW-1:0]     owner, owner_w;
  logic              busy, done, aborted, busy_w, done_w, aborted_w;
  logic [CW-1:0]     count;
  logic [3:0]        count_w;

  typedef struct { int own; int cnt; int abrt; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  cnt_arbiter #(.NREQ(NREQ), .CW(CW), .LW(LW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .clr(clr),
    .gnt(gnt), .owner(owner), .busy(busy), .done(done),
    .aborted(aborted), .count(count));

  // Narrow-counter twin driven identically; its count is the main count mod 16.
  cnt_arbiter #(.NREQ(NREQ), .CW(4), .LW(LW), .IW(IW)) dut_w (
    .clk(clk), .rst(rst), .req(req), .len(len), .clr(clr),
    .gnt(gnt_w), .owner(owner_w), .busy(busy_w), .done(done_w),
    .aborted(aborted_w), .count(count_w));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int o, input int c, input int a);
    exp_t e;
    e.own = o; e.cnt = c; e.abrt = a;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_owner", 32'(owner), 32'(e.own));
          chk("done_count", 32'(count), 32'(e.cnt));
          chk("done_aborted", 32'(aborted), 32'(e.abrt));
          chk("done_gnt", 32'(gnt), 32'd0);
          chk("done_count_w", 32'(count_w), 32'(e.cnt & 15));
        end
      end
    end
  end

  initial begin
    logic [NREQ-1:0] exp_g [4];
    exp_g[0] = 4'b0100; exp_g[1] = 4'b0001; exp_g[2] = 4'b0100; exp_g[3] = 4'b0001;
    rst = 1'b0; req = 4'b1111; len = '0; clr = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_owner", 32'(owner), 0);
    req = '0;
    edges(1);
    rst = 1'b1;
    edges(1);

    // single burst, len0=5
    req = 4'b0001; len[0*LW +: LW] = 8'd5;
    push(0, 5, 0);
    edges(1);
    chk("b1_gnt", 32'(gnt), 32'b0001);
    chk("b1_cnt0", 32'(count), 0);
    edges(5);
    chk("b1_done", 32'(done), 1);
    chk("b1_gnt_off", 32'(gnt), 0);
    chk("b1_cnt", 32'(count), 5);
    req = '0;
    edges(1);
    chk("b1_done_clr", 32'(done), 0);
    chk("b1_busy", 32'(busy), 0);

    // clr wins over pending req, then contention 2,0,2,0 (rr pointer is 1)
    clr = 1'b1; req = 4'b0101;
    len[0*LW +: LW] = 8'd2; len[2*LW +: LW] = 8'd2;
    push(2, 2, 0); push(0, 4, 0); push(2, 6, 0); push(0, 8, 0);
    edges(1);
    chk("clr_count", 32'(count), 0);
    chk("clr_nogrant", 32'(gnt), 0);
    clr = 1'b0;
    for (int b = 0; b < 4; b++) begin
      edges(1);
      chk("rr_gnt", 32'(gnt), 32'(exp_g[b]));
      edges(2);
      if (b == 3) req = '0;
      edges(1);
    end
    chk("rr_count", 32'(count), 8);

    // abort: owner 1 drops after 3 increments, requester 2 then served
    req = 4'b0110; len[1*LW +: LW] = 8'd10; len[2*LW +: LW] = 8'd1;
    push(1, 11, 1); push(2, 12, 0);
    edges(1);
    chk("ab_gnt", 32'(gnt), 32'b0010);
    edges(3);
    req = 4'b0100;
    edges(1);
    chk("ab_done", 32'(done), 1);
    chk("ab_aborted", 32'(aborted), 1);
    chk("ab_count", 32'(count), 11);
    edges(2);
    chk("ab_next_gnt", 32'(gnt), 32'b0100);
    edges(1);
    req = '0;
    edges(1);

    // len=0: done pulse with no grant, count untouched
    req = 4'b1000; len[3*LW +: LW] = 8'd0;
    push(3, 12, 0);
    edges(1);
    chk("z_gnt", 32'(gnt), 0);
    chk("z_done", 32'(done), 1);
    chk("z_count", 32'(count), 12);
    req = '0;
    edges(1);

    // wrap on the 4-bit twin: bring to 14, then burst of 3 -> 15,0,1
    req = 4'b0001; len[0*LW +: LW] = 8'd2;
    push(0, 14, 0);
    edges(3);
    req = '0;
    edges(1);
    chk("w_pre", 32'(count_w), 14);
    req = 4'b0001; len[0*LW +: LW] = 8'd3;
    push(0, 17, 0);
    edges(2);
    chk("w_15", 32'(count_w), 15);
    chk("w_15_done", 32'(done_w), 0);
    edges(1);
    chk("w_0", 32'(count_w), 0);
    chk("w_0_done", 32'(done_w), 0);
    edges(1);
    chk("w_1", 32'(count_w), 1);
    chk("w_1_done", 32'(done_w), 1);
    req = '0;
    edges(1);

    // asynchronous reset mid-burst
    req = 4'b0001; len[0*LW +: LW] = 8'd10;
    edges(3);
    chk("mr_running", 32'(count), 19);
    #2 rst = 1'b0;
    #1;
    chk("mr_gnt", 32'(gnt), 0);
    chk("mr_count", 32'(count), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_owner", 32'(owner), 0);
    req = '0;
    edges(1);
    rst = 1'b1;
    edges(4);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
